// File: rtl/sram_line_reader.sv
// Read-side initiator for the three-bank line SRAM: issues line bursts of read
// addresses, collects 1-cycle-latency read data into a 4-entry FIFO and streams it out.
module sram_line_reader #(
    parameter int AW = 10,
    parameter int DW = 128
) (
    input  logic          SYS_CLK,
    input  logic          SYS_RST,
    input  logic [3:0]    sram_status_i,
    input  logic          rd_start_i,
    input  logic          rd_two_i,
    input  logic [1:0]    rd_bank0_i,
    input  logic [1:0]    rd_bank1_i,
    input  logic [AW-1:0] rd_base_i,
    input  logic [AW-1:0] line_len_i,
    output logic [AW+1:0] raddr_o,
    output logic          raddr_vld_o,
    input  logic [DW-1:0] rdata_i,
    input  logic          rdata_vld_i,
    output logic [DW-1:0] dout_o,
    output logic          dout_vld_o,
    input  logic          dout_rdy_i,
    output logic          dout_last_o,
    output logic          dout_line_o,
    output logic          busy_o,
    output logic          rd_done_o,
    output logic          err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD_B0 = 2'd1;
    localparam logic [1:0] S_RD_B1 = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          two_q;
    logic [1:0]    bank0_q, bank1_q;
    logic [AW-1:0] base_q, len_q;
    logic [AW+1:0] raddr_q, raddr_d;
    logic          raddrVld_q, raddrVld_d;
    logic          tagLast_q, tagLast_d, tagLine_q, tagLine_d;
    logic          pipeVld_q, pipeLast_q, pipeLine_q;
    logic [2:0]    occ_q, occNxt;
    logic          rdDone_q, rdDone_d, err_q, err_d;

    logic [DW-1:0] memData_q [4];
    logic          memLast_q [4];
    logic          memLine_q [4];
    logic [1:0]    wrPtr_q, rdPtr_q;
    logic [2:0]    fifoCnt_q;

    logic          startOk, accept, pop, push, inRd, issueNow, lastWord, selLine, selTwo;
    logic [1:0]    selBank;
    logic [AW-1:0] selBase, selLen, selCnt, cntInc;

    assign startOk = ((sram_status_i == 4'b0100) || (sram_status_i == 4'b1000)) &&
                     (line_len_i != '0) && (rd_bank0_i != 2'd3) &&
                     (!rd_two_i || (rd_bank1_i != 2'd3));
    assign accept  = rd_start_i && (state_q == S_IDLE) && startOk;
    assign pop     = (fifoCnt_q != 3'd0) && dout_rdy_i;
    assign push    = rdata_vld_i && pipeVld_q;
    // Credits count words issued but not yet popped, so the FIFO can never overflow.
    assign occNxt  = occ_q + {2'b00, raddrVld_q} - {2'b00, pop};

    // On the accepting edge the first issue is taken straight from the inputs.
    always_comb begin
        inRd    = 1'b0;
        selBank = bank0_q;
        selBase = base_q;
        selLen  = len_q;
        selTwo  = two_q;
        selLine = 1'b0;
        selCnt  = cnt_q;
        if (accept) begin
            inRd    = 1'b1;
            selBank = rd_bank0_i;
            selBase = rd_base_i;
            selLen  = line_len_i;
            selTwo  = rd_two_i;
            selCnt  = '0;
        end else if (state_q == S_RD_B0) begin
            inRd = 1'b1;
        end else if (state_q == S_RD_B1) begin
            inRd    = 1'b1;
            selBank = bank1_q;
            selLine = 1'b1;
        end
    end

    assign issueNow = inRd && (occNxt < 3'd4);
    assign cntInc   = selCnt + {{(AW-1){1'b0}}, 1'b1};
    assign lastWord = (cntInc == selLen);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        raddr_d    = raddr_q;
        raddrVld_d = issueNow;
        tagLast_d  = tagLast_q;
        tagLine_d  = tagLine_q;
        rdDone_d   = 1'b0;
        err_d      = rd_start_i && (state_q == S_IDLE) && !startOk;
        if (accept) begin
            state_d = S_RD_B0;
            cnt_d   = '0;
        end
        if (issueNow) begin
            raddr_d   = {selBank, selBase + selCnt};
            cnt_d     = cntInc;
            tagLast_d = lastWord;
            tagLine_d = selLine;
            if (lastWord) begin
                cnt_d   = '0;
                state_d = (!selLine && selTwo) ? S_RD_B1 : S_DRAIN;
            end
        end
        if ((state_q == S_DRAIN) && (occNxt == 3'd0)) begin
            state_d  = S_IDLE;
            rdDone_d = 1'b1;
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            two_q      <= 1'b0;
            bank0_q    <= '0;
            bank1_q    <= '0;
            base_q     <= '0;
            len_q      <= '0;
            raddr_q    <= '0;
            raddrVld_q <= 1'b0;
            tagLast_q  <= 1'b0;
            tagLine_q  <= 1'b0;
            pipeVld_q  <= 1'b0;
            pipeLast_q <= 1'b0;
            pipeLine_q <= 1'b0;
            occ_q      <= '0;
            rdDone_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            raddr_q    <= raddr_d;
            raddrVld_q <= raddrVld_d;
            tagLast_q  <= tagLast_d;
            tagLine_q  <= tagLine_d;
            pipeVld_q  <= raddrVld_q;
            pipeLast_q <= tagLast_q;
            pipeLine_q <= tagLine_q;
            occ_q      <= occNxt;
            rdDone_q   <= rdDone_d;
            err_q      <= err_d;
            if (accept) begin
                two_q   <= rd_two_i;
                bank0_q <= rd_bank0_i;
                bank1_q <= rd_bank1_i;
                base_q  <= rd_base_i;
                len_q   <= line_len_i;
            end
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            for (int i = 0; i < 4; i++) begin
                memData_q[i] <= '0;
                memLast_q[i] <= 1'b0;
                memLine_q[i] <= 1'b0;
            end
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            fifoCnt_q <= '0;
        end else begin
            if (push) begin
                memData_q[wrPtr_q] <= rdata_i;
                memLast_q[wrPtr_q] <= pipeLast_q;
                memLine_q[wrPtr_q] <= pipeLine_q;
                wrPtr_q            <= wrPtr_q + 2'd1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            fifoCnt_q <= fifoCnt_q + {2'b00, push} - {2'b00, pop};
        end
    end

    assign raddr_o     = raddr_q;
    assign raddr_vld_o = raddrVld_q;
    assign dout_o      = memData_q[rdPtr_q];
    assign dout_last_o = memLast_q[rdPtr_q];
    assign dout_line_o = memLine_q[rdPtr_q];
    assign dout_vld_o  = (fifoCnt_q != 3'd0);
    assign busy_o      = (state_q != S_IDLE);
    assign rd_done_o   = rdDone_q;
    assign err_o       = err_q;

endmodule
